// File: rtl/signext_stream.sv
// Streaming sign/zero extender: i_n-bit field of i_x widened to M bits, delivered
// through a two-entry (main + skid) valid/ready output buffer with registered o_ready.
module signext_stream #(
  parameter int N_MAX = 20,
  parameter int M     = 32,
  parameter int NW    = $clog2(N_MAX + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N_MAX-1:0] i_x,
  input  logic [NW-1:0]    i_n,
  input  logic             i_sext,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [M-1:0]     o_y
);

  // Handshake: a beat moves on a rising edge only when its valid and ready are both
  // high; valid never waits on ready, and a presented beat stays stable until taken.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [M-1:0]     r_main;
  logic [M-1:0]     r_skid;
  logic             r_valid;
  logic             r_ready;

  logic             w_in;
  logic             w_out;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  logic [NW-1:0]    w_n_eff;
  logic [M-1:0]     w_x_ext;
  logic [M-1:0]     w_mask;
  logic             w_sign;
  logic [M-1:0]     w_result;

  // Field widths above N_MAX clamp to N_MAX; a zero-width field yields all zeros
  // because the mask is empty and no sign bit is selected.
  always_comb begin
    w_n_eff = (i_n > NW'(N_MAX)) ? NW'(N_MAX) : i_n;
    w_x_ext = '0;
    w_x_ext[N_MAX-1:0] = i_x;
    w_mask = (M'(1) << w_n_eff) - M'(1);
    w_sign = 1'b0;
    for (int i = 0; i < N_MAX; i++) begin
      if (w_n_eff == NW'(i + 1)) begin
        w_sign = i_x[i];
      end
    end
    w_result = (w_x_ext & w_mask) | ((i_sext & w_sign) ? ~w_mask : '0);
  end

  assign w_in  = i_valid & r_ready;
  assign w_out = r_valid & i_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in && w_out) begin
          w_load_main = 1'b1;
        end else if (w_in) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_out) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out) begin
          w_state_nxt      = ST_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Flags are registered from the next state so o_ready has no path from i_ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != ST_EMPTY);
      r_ready <= (w_state_nxt != ST_TWO);
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : w_result;
      end
      if (w_load_skid) begin
        r_skid <= w_result;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ready = r_ready;
  assign o_y     = r_main;

endmodule

// File: tb/tb_signext_stream.sv
// Bench for signext_stream: directed beats with hand-computed results pushed to a
// queue, a negedge monitor that pops and compares every delivered output beat.
module tb_signext_stream;

  localparam int N_MAX = 20;
  localparam int M     = 32;
  localparam int NW    = $clog2(N_MAX + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [N_MAX-1:0] i_x;
  logic [NW-1:0]    i_n;
  logic             i_sext;
  logic             o_valid;
  logic             i_ready;
  logic [M-1:0]     o_y;

  logic [M-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_phase = 1'b0;
  int rand_cnt   = 0;
  int rand_first = -1;
  int rand_last  = -1;
  bit c_done     = 1'b0;

  signext_stream #(.N_MAX(N_MAX), .M(M)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .i_n     (i_n),
    .i_sext  (i_sext),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_y     (o_y)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // independent reference: per-bit definition of the extension
  function automatic logic [M-1:0] model(input logic [N_MAX-1:0] x, input int n, input bit s);
    int ne;
    logic [M-1:0] y;
    ne = (n > N_MAX) ? N_MAX : n;
    y = '0;
    if (ne != 0) begin
      for (int i = 0; i < M; i++) y[i] = (i < ne) ? x[i] : (s & x[ne-1]);
    end
    return y;
  endfunction

  // driver tasks
  task automatic send(input logic [N_MAX-1:0] x, input logic [NW-1:0] n, input logic s,
                      input logic [M-1:0] exp);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    i_valid = 1'b1; i_x = x; i_n = n; i_sext = s;
    while (!o_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (!o_ready) begin
      n_fail++;
      $display("FAIL send_accept: o_ready got 0 expected 1 within 100 cycles");
      i_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected no beat", o_y);
      end else begin
        check("out_data", o_y, exp_q.pop_front());
      end
      if (rand_phase) begin
        rand_cnt++;
        if (rand_first < 0) rand_first = cyc;
        rand_last = cyc;
      end
    end
  end

  initial begin
    logic [N_MAX-1:0] rx;
    logic [NW-1:0]    rn;
    logic             rs;
    rst = 1'b1; i_valid = 1'b0; i_x = '0; i_n = '0; i_sext = 1'b0; i_ready = 1'b1;
    #3;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_ready", {31'd0, o_ready}, 32'd1);
    check("rst_o_y", o_y, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // first beat from EMPTY: valid one cycle after the accepting edge
    send(20'h80000, 5'd20, 1'b1, 32'hFFF80000);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("latency_o_valid", {31'd0, o_valid}, 32'd1);
    drain();

    // directed extension vectors, back to back
    send(20'hABC80, 5'd8,  1'b1, 32'hFFFFFF80);
    send(20'hABC80, 5'd8,  1'b0, 32'h00000080);
    send(20'hFFFFF, 5'd0,  1'b1, 32'h00000000);
    send(20'hFFFFF, 5'd25, 1'b1, 32'hFFFFFFFF);
    send(20'h00001, 5'd1,  1'b1, 32'hFFFFFFFF);
    send(20'hFFFFE, 5'd1,  1'b1, 32'h00000000);
    send(20'hFFFF7, 5'd4,  1'b1, 32'h00000007);
    send(20'h7FFFF, 5'd20, 1'b1, 32'h0007FFFF);
    send(20'h80000, 5'd31, 1'b0, 32'h00080000);
    idle();
    drain();

    // backpressure: two beats fill the buffer, third waits
    i_ready = 1'b0;
    send(20'h00F00, 5'd12, 1'b1, 32'hFFFFFF00);
    send(20'h12345, 5'd16, 1'b1, 32'h00002345);
    idle();
    check("full_o_ready", {31'd0, o_ready}, 32'd0);
    check("full_o_valid", {31'd0, o_valid}, 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      check("hold_o_y", o_y, 32'hFFFFFF00);
    end
    fork
      begin
        send(20'h00010, 5'd5, 1'b0, 32'h00000010);
        idle();
        c_done = 1'b1;
      end
    join_none
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("blocked_o_ready", {31'd0, o_ready}, 32'd0);
    i_ready = 1'b1;
    for (int k = 0; k < 100 && !c_done; k++) begin
      @(posedge clk); #1;
    end
    drain();

    // random beats, full throughput
    rand_phase = 1'b1;
    for (int b = 0; b < 100; b++) begin
      rx = N_MAX'($urandom);
      rn = NW'($urandom_range(31, 0));
      rs = 1'($urandom_range(1, 0));
      send(rx, rn, rs, model(rx, int'(rn), rs));
    end
    idle();
    drain();
    rand_phase = 1'b0;
    check("rand_count", rand_cnt, 32'd100);
    check("rand_span", rand_last - rand_first, 32'd99);

    // asynchronous reset mid-cycle while the buffer is full
    @(posedge clk); #1;
    i_ready = 1'b0;
    send(20'h00011, 5'd8, 1'b0, 32'h00000011);
    send(20'h00022, 5'd8, 1'b0, 32'h00000022);
    idle();
    check("pre_rst_o_ready", {31'd0, o_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("async_rst_o_ready", {31'd0, o_ready}, 32'd1);
    check("async_rst_o_y", o_y, 32'h0);
    exp_q.delete();
    #1 rst = 1'b0;
    i_ready = 1'b1;
    send(20'h00005, 5'd3, 1'b1, 32'hFFFFFFFD);
    idle();
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
